// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and display/LED outputs of the intersection phase controller.
// The board or bench drives through master; the controller uses slave.
interface traffic_phase_ctrl_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned LW  = 3,
    parameter int unsigned TW  = 6
);
    logic             Power;
    logic             Set;
    logic             Online;
    logic [LW-1:0]    line_ch;
    logic             Peaks;
    logic             Ten;
    logic [NCH-1:0]   car;
    logic [3*NCH-1:0] lights;
    logic [TW-1:0]    rest_time;
    logic [LW-1:0]    phase;
    logic [2:0]       ctrl_state;

    modport master (
        output Power, Set, Online, line_ch, Peaks, Ten, car,
        input  lights, rest_time, phase, ctrl_state
    );

    modport slave (
        input  Power, Set, Online, line_ch, Peaks, Ten, car,
        output lights, rest_time, phase, ctrl_state
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-group intersection controller: car-presence skipping, busy-hour
// greens, night flashing, pause freeze and manual online hold.
module traffic_phase_ctrl #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned LW         = 3,
    parameter int unsigned TW         = 6,
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned ORD_GREEN  = 25,
    parameter int unsigned BUSY_GREEN = 40,
    parameter int unsigned YELLOW     = 3,
    parameter int unsigned ALLRED     = 2
) (
    input logic                 clk,
    input logic                 Reset,
    traffic_phase_ctrl_if.slave bus
);
    localparam int unsigned     PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned     LWP      = LW + 1;
    localparam logic [PW-1:0]   TickLast = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0]   LastGrp  = LW'(NCH - 1);
    localparam logic [LWP-1:0]  NchW     = LWP'(NCH);
    localparam logic [TW-1:0]   TOrd     = TW'(ORD_GREEN);
    localparam logic [TW-1:0]   TBusy    = TW'(BUSY_GREEN);
    localparam logic [TW-1:0]   TYel     = TW'(YELLOW);
    localparam logic [TW-1:0]   TAr      = TW'(ALLRED);
    localparam logic [TW-1:0]   TOne     = TW'(1);
    localparam logic [2:0]      SymR     = 3'b100;
    localparam logic [2:0]      SymY     = 3'b010;
    localparam logic [2:0]      SymG     = 3'b001;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StGreen  = 3'd1,
        StYellow = 3'd2,
        StAllRed = 3'd3,
        StNight  = 3'd4,
        StPause  = 3'd5,
        StLine   = 3'd6
    } state_e;

    state_e           state_q, saved_q;
    logic [3*NCH-1:0] lights_q;
    logic [TW-1:0]    rest_q;
    logic [LW-1:0]    phase_q;
    logic [PW-1:0]    presc_q;
    logic             blink_q;
    logic             tick;
    logic [LW-1:0]    line_sel;

    // One group shows sym, every other group shows red.
    function automatic logic [3*NCH-1:0] show(input logic [2:0] sym, input logic [LW-1:0] grp);
        logic [3*NCH-1:0] v;
        for (int i = 0; i < NCH; i++) begin
            v[3*i +: 3] = (LW'(i) == grp) ? sym : SymR;
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] next_grp(input logic [LW-1:0] cur,
                                               input logic [NCH-1:0] present);
        logic [LW-1:0]  pick;
        logic           found;
        logic [NCH-1:0] sh;
        int             j;
        pick  = LW'((int'(cur) + 1) % NCH);
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            j  = (int'(cur) + i) % NCH;
            sh = present >> j;
            if (!found && sh[0]) begin
                pick  = LW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign tick     = (presc_q == TickLast);
    assign line_sel = ({1'b0, bus.line_ch} >= NchW) ? '0 : bus.line_ch;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StOff;
            saved_q  <= StOff;
            lights_q <= '0;
            rest_q   <= '0;
            phase_q  <= LastGrp;
            presc_q  <= '0;
            blink_q  <= 1'b0;
        end else if (state_q == StOff) begin
            presc_q <= '0;
            if (bus.Power) begin
                state_q  <= StAllRed;
                rest_q   <= TAr;
                phase_q  <= LastGrp;
                lights_q <= {NCH{SymR}};
            end else begin
                lights_q <= '0;
                rest_q   <= '0;
            end
        end else if (!bus.Power) begin
            state_q  <= StOff;
            lights_q <= '0;
            rest_q   <= '0;
            presc_q  <= '0;
        end else if (state_q == StPause) begin
            if (bus.Set) begin
                state_q <= saved_q;
            end
        end else if (!bus.Set) begin
            saved_q <= state_q;
            state_q <= StPause;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            // Mode changes are checked before the tick so a tick never lands on a fresh interval.
            case (state_q)
                StGreen: begin
                    if (bus.Online && phase_q == line_sel) begin
                        state_q  <= StLine;
                        rest_q   <= '0;
                        lights_q <= show(SymG, line_sel);
                    end else if (bus.Online || (tick && rest_q == TOne)) begin
                        state_q  <= StYellow;
                        rest_q   <= TYel;
                        lights_q <= show(SymY, phase_q);
                    end else if (bus.Ten) begin
                        state_q  <= StNight;
                        blink_q  <= 1'b1;
                        rest_q   <= '0;
                        lights_q <= {NCH{SymY}};
                    end else if (tick) begin
                        rest_q <= rest_q - TOne;
                    end
                end
                StYellow: begin
                    if (!bus.Online && bus.Ten) begin
                        state_q  <= StNight;
                        blink_q  <= 1'b1;
                        rest_q   <= '0;
                        lights_q <= {NCH{SymY}};
                    end else if (tick && rest_q == TOne) begin
                        state_q  <= StAllRed;
                        rest_q   <= TAr;
                        lights_q <= {NCH{SymR}};
                    end else if (tick) begin
                        rest_q <= rest_q - TOne;
                    end
                end
                StAllRed: begin
                    if (!bus.Online && bus.Ten) begin
                        state_q  <= StNight;
                        blink_q  <= 1'b1;
                        rest_q   <= '0;
                        lights_q <= {NCH{SymY}};
                    end else if (tick && rest_q == TOne && bus.Online) begin
                        state_q  <= StLine;
                        phase_q  <= line_sel;
                        rest_q   <= '0;
                        lights_q <= show(SymG, line_sel);
                    end else if (tick && rest_q == TOne) begin
                        state_q  <= StGreen;
                        phase_q  <= next_grp(phase_q, bus.car);
                        rest_q   <= bus.Peaks ? TBusy : TOrd;
                        lights_q <= show(SymG, next_grp(phase_q, bus.car));
                    end else if (tick) begin
                        rest_q <= rest_q - TOne;
                    end
                end
                StLine: begin
                    if (!bus.Online || line_sel != phase_q) begin
                        state_q  <= StYellow;
                        rest_q   <= TYel;
                        lights_q <= show(SymY, phase_q);
                    end
                end
                StNight: begin
                    if (bus.Online || !bus.Ten) begin
                        state_q  <= StAllRed;
                        rest_q   <= TAr;
                        phase_q  <= LastGrp;
                        lights_q <= {NCH{SymR}};
                    end else if (tick) begin
                        blink_q  <= ~blink_q;
                        lights_q <= blink_q ? '0 : {NCH{SymY}};
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign bus.lights     = lights_q;
    assign bus.rest_time  = rest_q;
    assign bus.phase      = phase_q;
    assign bus.ctrl_state = state_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs per clock,
// a monitor pops and compares them shortly after each rising edge.
module tb_traffic_phase_ctrl;
    localparam int unsigned NCH = 3;
    localparam int unsigned LW  = 3;
    localparam int unsigned TW  = 6;

    localparam logic [2:0] SOff = 3'd0, SGreen = 3'd1, SYellow = 3'd2, SAllRed = 3'd3;
    localparam logic [2:0] SNight = 3'd4, SPause = 3'd5, SLine = 3'd6;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam logic [8:0] AllR = 9'b100_100_100;
    localparam logic [8:0] AllY = 9'b010_010_010;
    localparam int         AnyPh = 7;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] rest;
        logic [2:0] ph;
        logic [8:0] lt;
    } exp_t;

    logic   clk = 1'b0;
    logic   Reset;
    exp_t   exp_q[$];
    string  tag_q[$];
    int     checks = 0;
    int     errors = 0;

    traffic_phase_ctrl_if #(.NCH(NCH), .LW(LW), .TW(TW)) bus ();

    traffic_phase_ctrl #(
        .NCH(NCH), .LW(LW), .TW(TW), .TICK_DIV(1), .ORD_GREEN(5), .BUSY_GREEN(8),
        .YELLOW(2), .ALLRED(1)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e, input string tag);
        checks++;
        if (bus.ctrl_state !== e.st || bus.rest_time !== e.rest || bus.lights !== e.lt ||
            (e.ph != 3'(AnyPh) && bus.phase !== e.ph)) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d rest=%0d ph=%0d lights=%b, want st=%0d rest=%0d ph=%0d lights=%b",
                     tag, $time, bus.ctrl_state, bus.rest_time, bus.phase, bus.lights,
                     e.st, e.rest, e.ph, e.lt);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 2 time units later.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) compare(exp_q.pop_front(), tag_q.pop_front());
        end
    end

    function automatic logic [8:0] show(input logic [2:0] sym, input int g);
        logic [8:0] v;
        for (int i = 0; i < 3; i++) v[3*i +: 3] = (i == g) ? sym : R;
        return v;
    endfunction

    task automatic step(input logic [2:0] st, input int rest, input int ph, input logic [8:0] lt,
                        input string tag);
        exp_t e;
        e.st   = st;
        e.rest = 6'(rest);
        e.ph   = 3'(ph);
        e.lt   = lt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic green(input int g, input int r);  step(SGreen, r, g, show(G, g), "green");   endtask
    task automatic yellow(input int g, input int r); step(SYellow, r, g, show(Y, g), "yellow"); endtask
    task automatic allred(input int g);              step(SAllRed, 1, g, AllR, "allred");       endtask
    task automatic line(input int g);                step(SLine, 0, g, show(G, g), "line");     endtask
    task automatic pause(input int g, input int r);  step(SPause, r, g, show(G, g), "pause");   endtask
    task automatic night(input bit on);
        step(SNight, 0, AnyPh, on ? AllY : 9'd0, "night");
    endtask

    task automatic round_from(input int g, input int r0);
        for (int r = r0; r >= 1; r--) green(g, r);
        yellow(g, 2);
        yellow(g, 1);
        allred(g);
    endtask

    initial begin
        exp_t e;
        Reset = 1'b0;
        bus.Power = 1'b0; bus.Set = 1'b1; bus.Online = 1'b0; bus.line_ch = '0;
        bus.Peaks = 1'b0; bus.Ten = 1'b0; bus.car = 3'b111;
        step(SOff, 0, 2, 9'd0, "reset");
        bus.Power = 1'b1;
        step(SOff, 0, 2, 9'd0, "reset_hold");
        Reset = 1'b1;
        allred(2);
        round_from(0, 5);
        green(1, 5);
        // Only group2 has traffic: it should win every selection.
        bus.car = 3'b100;
        round_from(1, 4);
        round_from(2, 5);
        green(2, 5);
        bus.car = 3'b000;
        round_from(2, 4);
        round_from(0, 5);
        green(1, 5);
        bus.Peaks = 1'b1;
        round_from(1, 4);
        green(2, 8);
        bus.Peaks = 1'b0;
        round_from(2, 7);
        green(0, 5);
        green(0, 4);
        bus.car = 3'b111;
        bus.Online = 1'b1; bus.line_ch = 3'd2;
        yellow(0, 2); yellow(0, 1); allred(0);
        line(2); line(2); line(2);
        bus.Online = 1'b0;
        yellow(2, 2); yellow(2, 1); allred(2);
        green(0, 5);
        // Hold on the green group, then exercise clamping and a held-group change.
        bus.Online = 1'b1; bus.line_ch = 3'd0;
        line(0); line(0);
        bus.line_ch = 3'd5;
        line(0); line(0);
        bus.line_ch = 3'd1;
        yellow(0, 2); yellow(0, 1); allred(0);
        line(1); line(1);
        bus.Online = 1'b0;
        yellow(1, 2); yellow(1, 1); allred(1);
        round_from(2, 5);
        round_from(0, 5);
        green(1, 5); green(1, 4); green(1, 3);
        bus.Set = 1'b0;
        repeat (10) pause(1, 3);
        bus.Set = 1'b1;
        round_from(1, 3);
        green(2, 5);
        bus.Ten = 1'b1; bus.Online = 1'b1; bus.line_ch = 3'd2;
        line(2);
        bus.Online = 1'b0;
        yellow(2, 2);
        night(1); night(0); night(1); night(0);
        bus.Ten = 1'b0;
        allred(2);
        green(0, 5);
        bus.Ten = 1'b1;
        night(1); night(0);
        // Asynchronous reset must act before the next rising edge.
        #2 Reset = 1'b0;
        #1;
        e.st = SOff; e.rest = '0; e.ph = 3'd2; e.lt = '0;
        compare(e, "async_reset");
        bus.Ten = 1'b0;
        step(SOff, 0, 2, 9'd0, "reset_hold2");
        Reset = 1'b1;
        allred(2);
        green(0, 5); green(0, 4);
        bus.Power = 1'b0;
        step(SOff, 0, AnyPh, 9'd0, "off");
        bus.Set = 1'b0;
        step(SOff, 0, AnyPh, 9'd0, "off_set0");
        bus.Set = 1'b1; bus.Power = 1'b1;
        allred(2);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-approach intersection controller. It is the successor to the two-road main/sub controller. Phases are sequenced round-robin over NCH signal groups with per-mode green lengths, car-presence phase skipping, night flashing, pause freeze and manual online hold. It sits under the board top and drives per-group RYG LEDs plus the remaining-time value for the 7-segment display block.

Parameters:
NCH, 4, number of signal groups (2..8)
LW, 3, width of line_ch (>= clog2(NCH))
TW, 6, remaining-time counter width
TICK_DIV, 100000000, clk cycles per 1 s tick (1 allowed for simulation)
ORD_GREEN, 25, green ticks in ordinary mode
BUSY_GREEN, 40, green ticks when Peaks=1
YELLOW, 3, yellow ticks
ALLRED, 2, all-red clearance ticks

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Power  in  1  1 = run, 0 = OFF (synchronous)
Set  in  1  0 = pause/freeze
Online  in  1  manual hold request
line_ch  in  LW  group held green while Online
Peaks  in  1  busy-hour timing
Ten  in  1  night flashing mode
car  in  NCH  per-group vehicle present
lights  out  3*NCH  group i = bits [3i+2:3i] = {R,Y,G}
rest_time  out  TW  remaining ticks of current interval
phase  out  LW  current active group
ctrl_state  out  3  OFF=0 GREEN=1 YELLOW=2 ALLRED=3 NIGHT=4 PAUSE=5 LINE=6

Behaviour:
- All outputs are registered. Reset=0 (asynchronous): ctrl_state=OFF, lights=0, rest_time=0, phase=NCH-1, prescaler=0, blink=0, saved state=OFF.
- Prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap. It is frozen in PAUSE and cleared in OFF.
- Priority, evaluated each clk in any non-OFF state: Power=0 > Set=0 > Online > Ten > normal sequencing.
- OFF: lights all 0, rest_time 0. Power=1 -> ALLRED with rest_time=ALLRED and phase=NCH-1.
- Power=0 from any state -> OFF on the next edge.
- GREEN: lights[phase]=G, others R. On entry, rest_time = Peaks ? BUSY_GREEN : ORD_GREEN. Peaks is sampled at entry only.
  - Each tick decrements rest_time.
  - Tick at rest_time==1 -> YELLOW, rest_time=YELLOW.
- YELLOW: phase Y, others R. Tick at 1 -> ALLRED, rest_time=ALLRED.
- ALLRED: all R. Tick at 1 -> select the next group, then enter GREEN.
  - Next group: first index after phase (mod NCH, round-robin) with car=1.
  - If car==0 everywhere: (phase+1) mod NCH.
  - Exception: if an Online hold is pending, enter LINE instead.
- Each interval lasts exactly its parameter count of ticks.
- Online=1 handling:
  - In GREEN with phase==line_ch (clamped): -> LINE next edge.
  - In GREEN otherwise: -> YELLOW immediately (rest_time=YELLOW).
  - In YELLOW/ALLRED: complete normally; on ALLRED expiry, phase=line_ch -> LINE.
  - In NIGHT: -> ALLRED (rest_time=ALLRED).
  - line_ch >= NCH is clamped to 0.
- LINE: line_ch green, others R, rest_time=0, no timeout.
  - Online=0 or line_ch changes -> YELLOW on the held group, then the normal path.
  - On a line_ch change, the ALLRED exit enters LINE on the new group.
- NIGHT: entered from GREEN/YELLOW/ALLRED when Ten=1 and Online=0.
  - All groups show Y when blink=1, else 0. blink toggles each tick and starts at 1. rest_time=0.
  - Ten=0 -> ALLRED, rest_time=ALLRED, phase=NCH-1.
- PAUSE: entered when Set=0. Saves ctrl_state; lights, rest_time, phase and prescaler hold. Set=1 -> restore the saved state next edge and continue counting from the frozen value.
  - Power=0 in PAUSE -> OFF.
- Simultaneous Ten and Online: Online wins.
- Simultaneous tick and mode change: the mode change wins, and the tick is not applied to the new interval.
- Reset mid-operation: immediate return to the reset values.

Test Plan:
Common settings: NCH=3, TICK_DIV=1, ORD_GREEN=5, BUSY_GREEN=8, YELLOW=2, ALLRED=1.
- Reset low then high, Power=1, car=3'b111 -> ALLRED 1 tick, then group0 G for 5 ticks (rest_time 5..1), Y 2, ALLRED 1, then group1 G; lights=9'b100_100_001 during group0 green.
- car=3'b100 steady -> group2 green after every ALLRED, and groups 0/1 are never green; car=0 -> plain 0,1,2 rotation.
- Peaks=1 asserted mid-green -> current green unaffected; next green loads rest_time=8.
- Online=1, line_ch=2 while group0 green at rest_time=4 -> next edge YELLOW (rest_time=2), ALLRED, then LINE with group2 G indefinitely; Online=0 -> Y 2, ALLRED 1, then GREEN on group0 (car=111).
- Set=0 at group1 green rest_time=3 for 10 cycles -> all outputs frozen and ctrl_state=5; Set=1 -> GREEN resumes at 3.
- Ten=1 -> NIGHT, lights alternate 9'b010_010_010 / 0 per tick; Reset pulsed low mid-NIGHT -> lights=0 and ctrl_state=0 asynchronously, before the next clk edge.
